// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the cache-to-RAM arbiter.
// Covers RAM handshake states, arbiter FSM states and the round-robin source tag.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Which cache held the most recent grant; drives the round-robin tie-break.
    typedef enum logic {
        SRC_ICACHE = 1'b0,
        SRC_DCACHE = 1'b1
    } src_t;

    localparam int BURST_WORDS_DEF = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-port signals seen by the arbiter.
// slave = arbiter side, master = the caches and RAM model driving it.
interface mem_arbiter_if;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output ram_err
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  ram_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache onto one single-ported RAM, holding a dcache
// grant for up to BURST_WORDS words so block transfers are never split.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(BURST_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);

    arb_state_t       state,       state_n;
    logic [CNT_W-1:0] burst_cnt,   burst_cnt_n;
    src_t             last_served, last_served_n;
    logic             ram_err_q;

    logic d_req;
    logic ram_access;

    assign d_req      = bus.dREN | bus.dWEN;
    assign ram_access = (bus.ramstate == ACCESS);
    assign bus.ram_err = ram_err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= SRC_ICACHE;
            ram_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            burst_cnt   <= burst_cnt_n;
            last_served <= last_served_n;
            if (state != IDLE && bus.ramstate == ERROR)
                ram_err_q <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_n       = state;
        burst_cnt_n   = burst_cnt;
        last_served_n = last_served;
        bus.iwait     = 1'b1;
        bus.iload     = '0;
        bus.dwait     = 1'b1;
        bus.dload     = '0;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;

        unique case (state)
            IDLE: begin
                // On a tie the cache that was not served last wins.
                if (d_req && (!bus.iREN || last_served == SRC_ICACHE))
                    state_n = DGRANT;
                else if (bus.iREN)
                    state_n = IGRANT;
            end

            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;

                if (!d_req) begin
                    state_n       = IDLE;
                    burst_cnt_n   = '0;
                    last_served_n = SRC_DCACHE;
                end else if (ram_access) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    if (burst_cnt == LAST_WORD) begin
                        state_n       = IDLE;
                        burst_cnt_n   = '0;
                        last_served_n = SRC_DCACHE;
                    end else begin
                        burst_cnt_n = burst_cnt + CNT_W'(1);
                    end
                end
            end

            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;

                if (!bus.iREN) begin
                    state_n = IDLE;
                end else if (ram_access) begin
                    bus.iwait     = 1'b0;
                    bus.iload     = bus.ramload;
                    state_n       = IDLE;
                    last_served_n = SRC_ICACHE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the icache and dcache request interfaces; the other end of the dREN/dWEN/daddr/dstore/dload/dwait handshake the caches drive.
- Arbitrates both caches onto one single-ported RAM port and generates the iwait/dwait responses.
- Holds a dcache grant across a multi-word block fill or writeback, so icache traffic cannot split a block transfer.

Parameters:
BURST_WORDS, 2, maximum number of words the dcache may transfer under one grant (block size in words).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
iREN  in  1  icache read request.
iaddr  in  32  icache word address.
iwait  out  1  0 = iload valid this cycle; 1 = stall.
iload  out  32  icache read data.
dREN  in  1  dcache read request.
dWEN  in  1  dcache write request; wins if asserted together with dREN.
daddr  in  32  dcache word address.
dstore  in  32  dcache write data.
dwait  out  1  0 = access completes this cycle; 1 = stall.
dload  out  32  dcache read data.
ramREN  out  1  RAM read strobe.
ramWEN  out  1  RAM write strobe.
ramaddr  out  32  RAM address.
ramstore  out  32  RAM write data.
ramload  in  32  RAM read data.
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
ram_err  out  1  sticky flag: ERROR was seen during a grant.

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE; burst count 0; last-served = icache.
  - iwait=dwait=1; iload=dload=0; ramREN=ramWEN=0; ramaddr=ramstore=0; ram_err=0.
  - Reset asserted mid-transfer abandons the access; no wait is ever dropped for it.
- State machine, registered state:
  - IDLE:
    - dREN|dWEN with no iREN -> DGRANT.
    - iREN with no dcache request -> IGRANT.
    - Both requesting: grant the one not last-served (round-robin).
    - No RAM strobes while in IDLE.
  - DGRANT:
    - ramWEN=dWEN and ramREN=dREN&~dWEN, gated by the live request.
    - ramaddr=daddr; ramstore=dstore.
    - When ramstate==ACCESS: dwait=0 for that cycle, dload=ramload, burst count increments.
    - Return to IDLE when the count reaches BURST_WORDS, or on any cycle with dREN=dWEN=0. Then clear the count and set last-served = dcache.
  - IGRANT:
    - ramREN=iREN; ramaddr=iaddr.
    - When ramstate==ACCESS: iwait=0 for that cycle, iload=ramload, then -> IDLE with last-served = icache.
    - If iREN drops before ACCESS: -> IDLE with no completion.
- Waits:
  - The non-granted requester's wait stays 1.
  - Wait is 0 for exactly the one cycle in which ramstate==ACCESS.
  - Load outputs are 0 whenever the corresponding wait is 1.
- Latency:
  - A request first seen in IDLE at cycle n drives the RAM from cycle n+1.
  - If RAM returns ACCESS on its first cycle, the earliest wait=0 is cycle n+1.
  - The address may change between burst words; each word is driven combinationally from the live daddr.
- RAM states:
  - BUSY and FREE during a grant: hold the grant with wait=1.
  - ERROR: treated as BUSY (no completion) and sets ram_err, which stays 1 until reset.
- Requests that arrive mid-grant: the other requester waits until the grant ends; no preemption.

Decomposition:
- diaosi_types_pkg gains:
  - ramstate_t (FREE/BUSY/ACCESS/ERROR, 2 bits).
  - arb_state_t (IDLE/DGRANT/IGRANT).
  - Constant BURST_WORDS_DEF=2.
- No sub-module: FSM, burst counter and round-robin bit fit in one block (~200 lines).

Test Plan:
- Single icache read: iREN=1, iaddr=0x40; RAM gives ACCESS one cycle after ramREN with ramload=0xDEADBEEF -> iwait=0 for exactly one cycle with iload=0xDEADBEEF; FSM back in IDLE; dwait stays 1.
- Dcache two-word fill with icache contending: dREN on 0x80 then 0x84, iREN=1 throughout, RAM ACCESS after 2 BUSY cycles each -> ramaddr 0x80 then 0x84, both under DGRANT; iwait=1 until the second dcache word completes; icache granted next.
- Simultaneous first requests after reset (last-served = icache): dREN and iREN in the same cycle -> dcache granted first; the following arbitration goes to icache.
- Writeback: dWEN=1, dREN=1 at 0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait=0 on ACCESS.
- Abort and error: dREN deasserted while ramstate=BUSY -> IDLE next cycle, dwait never 0. Then ramstate=ERROR during an IGRANT -> ram_err=1 and stays 1; iwait=1.
- Reset mid-burst: RST pulsed after the first dcache word -> all outputs return to reset values immediately; the next dREN restarts with burst count 0.
